// File: rtl/rot_ddr_pkg.sv
// Shared types and constants for the rotation DDRAM command scheduler.
package rot_ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RWAIT = 2'd3
  } state_e;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BE_W    = 8;
  localparam int unsigned DEF_AW  = 29;
  localparam int unsigned ENTRY_W = DEF_AW + DATA_W + BE_W;
  localparam logic [7:0]  BURST1  = 8'd1;

  // Entry width for an arbitrary address width: {addr, data, be}.
  function automatic int unsigned entry_w(input int unsigned aw);
    return aw + DATA_W + BE_W;
  endfunction

endpackage

// File: rtl/rot_ddr_fifo.sv
// Register-array FIFO buffering pixel write commands; DEPTH must be a power of two.
module rot_ddr_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop_i) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push_i && pop_i) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/rot_ddr_sched.sv
// Arbitrates buffered rotation pixel writes against single-beat reads on one DDRAM port.
module rot_ddr_sched
  import rot_ddr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic              CLK_VIDEO,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  output logic              wr_full,
  output logic [7:0]        wr_drop,
  input  logic              rd_req,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              DDRAM_CLK,
  input  logic              DDRAM_BUSY,
  output logic [7:0]        DDRAM_BURSTCNT,
  output logic [AW-1:0]     DDRAM_ADDR,
  output logic [DATA_W-1:0] DDRAM_DIN,
  output logic [BE_W-1:0]   DDRAM_BE,
  output logic              DDRAM_WE,
  output logic              DDRAM_RD,
  input  logic [DATA_W-1:0] DDRAM_DOUT,
  input  logic              DDRAM_DOUT_READY
);

  localparam int unsigned EW = entry_w(AW);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [EW-1:0]     fifo_din, fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty, fifo_has;
  logic              push, pop;
  logic [AW-1:0]     head_addr;
  logic [DATA_W-1:0] head_data;
  logic [BE_W-1:0]   head_be;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              we_q, we_d, rd_q, rd_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              ack_q, ack_d, valid_q, valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        drop_q, drop_d;

  assign fifo_din = {wr_addr, wr_data, wr_be};
  assign push     = wr_req & ~fifo_full;
  assign fifo_has = (fifo_count != '0);
  assign {head_addr, head_data, head_be} = fifo_dout;

  rot_ddr_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (CLK_VIDEO),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Command registers are loaded with next-state values so WE/RD track the FSM state.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    we_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    be_d    = be_q;
    ack_d   = 1'b0;
    valid_d = 1'b0;
    rdata_d = rdata_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fifo_has && (!rd_req || !prio_q)) begin
          state_d = ST_WRITE;
          we_d    = 1'b1;
          addr_d  = head_addr;
          din_d   = head_data;
          be_d    = head_be;
        end else if (rd_req) begin
          state_d = ST_READ;
          rd_d    = 1'b1;
          addr_d  = rd_addr;
        end
      end
      ST_WRITE: begin
        if (DDRAM_BUSY) begin
          we_d = 1'b1;
        end else begin
          pop     = ~fifo_empty;
          prio_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (DDRAM_BUSY) begin
          rd_d = 1'b1;
        end else begin
          ack_d   = 1'b1;
          prio_d  = 1'b0;
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (DDRAM_DOUT_READY) begin
          rdata_d = DDRAM_DOUT;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A request seen while full is lost even if the head pops in the same cycle.
  always_comb begin
    drop_d = drop_q;
    if (wr_req && fifo_full && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
    end
  end

  assign wr_full        = fifo_full;
  assign wr_drop        = drop_q;
  assign rd_ack         = ack_q;
  assign rd_data        = rdata_q;
  assign rd_valid       = valid_q;
  assign DDRAM_CLK      = CLK_VIDEO;
  assign DDRAM_BURSTCNT = BURST1;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_WE       = we_q;
  assign DDRAM_RD       = rd_q;

endmodule
